// File: rtl/multi_lane_cdb.sv
// Multi-lane common data bus: per-FU result FIFOs drained onto NUM_CDB broadcast
// lanes by a rotating-priority arbiter that grants up to one lane per FU per cycle.

package multi_lane_cdb_pkg;
  localparam int TOTAL_FU = 4;
  typedef struct packed {
    logic [5:0]  tag;
    logic [25:0] value;
  } cdb_entry_t;
endpackage

module cdb_fu_buf
  import multi_lane_cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  cdb_entry_t       din,
  output cdb_entry_t       head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  // Explicit wrap so non-power-of-two depths index correctly
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !clr) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
endmodule

module multi_lane_cdb
  import multi_lane_cdb_pkg::*;
#(
  parameter int NUM_FU    = TOTAL_FU,
  parameter int NUM_CDB   = 2,
  parameter int BUF_DEPTH = 2,
  localparam int SRC_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  cdb_entry_t [NUM_FU-1:0]          fu_complete,
  input  logic [NUM_FU-1:0]                fu_complete_valid,
  output logic [NUM_FU-1:0]                fu_complete_ready,
  output cdb_entry_t [NUM_CDB-1:0]         cdb_data,
  output logic [NUM_CDB-1:0]               cdb_valid,
  output logic [NUM_CDB-1:0][SRC_W-1:0]    cdb_src,
  output logic [NUM_FU-1:0][CNT_W-1:0]     buf_count
);
  localparam int LANE_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;
  localparam logic [SRC_W-1:0] LAST_FU = SRC_W'(NUM_FU - 1);

  logic [NUM_FU-1:0]             avail, grant;
  cdb_entry_t [NUM_FU-1:0]       head;
  logic [SRC_W-1:0]              rr_ptr, last_fu, fu_sel;
  logic [NUM_CDB-1:0][SRC_W-1:0] lane_fu;
  logic [NUM_CDB-1:0]            lane_vld;
  logic [LANE_W-1:0]             lane_sel;
  int                            lanes_used, scan_idx;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    // Ready ignores same-cycle pops so a full buffer never accepts a result
    assign fu_complete_ready[g] = rst || ((buf_count[g] < CNT_W'(BUF_DEPTH)) && !flush);
    assign avail[g] = (buf_count[g] != '0) && !rst && !flush;

    cdb_fu_buf #(.DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (fu_complete_valid[g] && fu_complete_ready[g]),
      .pop   (grant[g]),
      .din   (fu_complete[g]),
      .head  (head[g]),
      .count (buf_count[g])
    );
  end

  // Scan from rr_ptr, filling lanes in order with the first non-empty buffers
  always_comb begin
    grant      = '0;
    lane_fu    = '0;
    lane_vld   = '0;
    last_fu    = rr_ptr;
    lanes_used = 0;
    scan_idx   = 0;
    fu_sel     = '0;
    lane_sel   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
      fu_sel   = SRC_W'(scan_idx);
      lane_sel = LANE_W'(lanes_used);
      if (lanes_used < NUM_CDB && avail[fu_sel]) begin
        grant[fu_sel]      = 1'b1;
        lane_fu[lane_sel]  = fu_sel;
        lane_vld[lane_sel] = 1'b1;
        last_fu            = fu_sel;
        lanes_used         = lanes_used + 1;
      end
    end
  end

  for (genvar l = 0; l < NUM_CDB; l++) begin : g_lane
    assign cdb_valid[l] = lane_vld[l];
    assign cdb_src[l]   = lane_fu[l];
    assign cdb_data[l]  = lane_vld[l] ? head[lane_fu[l]] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush)  rr_ptr <= '0;
    else if (|grant)   rr_ptr <= (last_fu == LAST_FU) ? '0 : last_fu + 1'b1;
  end

`ifndef SYNTHESIS
  int unsigned busy_cycles, starved_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cycles    <= 0;
      starved_cycles <= 0;
    end else begin
      if (|lane_vld)        busy_cycles    <= busy_cycles + 1;
      if (|(avail & ~grant)) starved_cycles <= starved_cycles + 1;
    end
  end

  final $display("multi_lane_cdb stats: busy_cycles=%0d starved_cycles=%0d",
                 busy_cycles, starved_cycles);
`endif
endmodule
